video_timing: RTL

Parametrised CRTC-style raster timing generator, the next generation of the PET video timing generator. It divides `pixel_clk` into character cells and runs horizontal character, scanline (raster), and vertical character-row counters with a vertical-adjust phase. It produces sync and active windows, a linear video memory address with programmable start, a raster row index for character ROM lookup, and a frame marker. It sits between the bus strobes and the pixel shifter, and widens the fixed 40/80-column timing to arbitrary geometry.

---
 rtl/video_timing_pkg.sv | 24 ++
 rtl/video_cursor.sv | 60 ++++++
 rtl/video_timing.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/video_timing_pkg.sv
// video_timing_pkg: shared types and constants for the raster timing generator.
//   vstate_e   - vertical phase: character rows or post-frame adjust scanlines
//   Def*       - default widths used as parameter defaults by video_timing
//   Cursor*    - cursor_mode encodings (used when VIDEO_TIMING_CURSOR_EN is defined)
package video_timing_pkg;

  typedef enum logic {
    VRows   = 1'b0,
    VAdjust = 1'b1
  } vstate_e;

  localparam int unsigned DefPixelsPerChar = 8;
  localparam int unsigned DefHWidth        = 8;
  localparam int unsigned DefVWidth        = 7;
  localparam int unsigned DefRWidth        = 5;
  localparam int unsigned DefMaWidth       = 14;
  localparam int unsigned VsyncCntWidth    = 4;

  localparam logic [1:0] CursorSteady  = 2'b00;
  localparam logic [1:0] CursorOff     = 2'b01;
  localparam logic [1:0] CursorBlink16 = 2'b10;
  localparam logic [1:0] CursorBlink32 = 2'b11;

endpackage

// File: rtl/video_cursor.sv
// video_cursor: hardware cursor compare plus blink frame counter.
// Only instantiated when VIDEO_TIMING_CURSOR_EN is defined.
// Ports:
//   pixel_clk, reset          - clock, async active-high reset
//   frame_tick                - high on the cycle whose state is the frame origin
//   de_next, ma_next, ra_next - unregistered display enable / address / raster
//   cursor_addr/start/end     - cursor cell address and raster span (inclusive)
//   cursor_mode               - steady / off / blink 16 on-16 off / blink 32 on-32 off
//   cursor                    - registered, aligned with the other timing outputs
module video_cursor
  import video_timing_pkg::*;
#(
  parameter int unsigned MA_WIDTH = DefMaWidth,
  parameter int unsigned R_WIDTH  = DefRWidth
) (
  input  logic                pixel_clk,
  input  logic                reset,
  input  logic                frame_tick,
  input  logic                de_next,
  input  logic [MA_WIDTH-1:0] ma_next,
  input  logic [R_WIDTH-1:0]  ra_next,
  input  logic [MA_WIDTH-1:0] cursor_addr,
  input  logic [R_WIDTH-1:0]  cursor_start,
  input  logic [R_WIDTH-1:0]  cursor_end,
  input  logic [1:0]          cursor_mode,
  output logic                cursor
);

  logic [4:0] frame_cnt_q;
  logic       slow_phase_q;  // toggles every 32 frames, on each frame_cnt_q wrap
  logic       blink_on;
  logic       cursor_d;

  always_comb begin
    blink_on = 1'b1;
    unique case (cursor_mode)
      CursorSteady:  blink_on = 1'b1;
      CursorOff:     blink_on = 1'b0;
      CursorBlink16: blink_on = ~frame_cnt_q[4];
      CursorBlink32: blink_on = ~slow_phase_q;
    endcase
    cursor_d = de_next && (ma_next == cursor_addr) && (ra_next >= cursor_start) &&
               (ra_next <= cursor_end) && blink_on;
  end

  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      frame_cnt_q  <= '0;
      slow_phase_q <= 1'b0;
      cursor       <= 1'b0;
    end else begin
      cursor <= cursor_d;
      if (frame_tick) begin
        frame_cnt_q <= frame_cnt_q + 5'd1;
        if (&frame_cnt_q) slow_phase_q <= ~slow_phase_q;
      end
    end
  end

endmodule

// File: rtl/video_timing.sv
// video_timing: CRTC-style raster timing generator.
// Counters: px (pixel in cell), hc (char in line), ra (raster in row / adjust line),
// vc (char row), plus a vertical phase (rows / adjust) and the row base address.
// Every output is registered from the current counter state, so all outputs lag
// the counters by exactly one pixel_clk.
// Ports:
//   pixel_clk, reset            - sole clock, async active-high reset
//   h_char_total/displayed      - last char index / displayed chars per line
//   h_sync_pos/width            - hsync start char / width in chars (0 = none)
//   v_char_total/displayed      - last row index / displayed rows
//   v_sync_pos/width            - vsync start row / width in scanlines (0 = none)
//   v_char_height, v_adjust     - last raster index in a row / extra scanlines
//   start_addr                  - address of the first displayed char
//   ma, ra                      - video RAM address, raster row within char
//   h_sync, v_sync, h_active, v_active, de, char_en, frame_start
// Option: define VIDEO_TIMING_CURSOR_EN to add cursor_addr, cursor_start, cursor_end,
// cursor_mode inputs and the cursor output (video_cursor sub-module).
// Configuration inputs are used live; there are no shadow registers.
module video_timing
  import video_timing_pkg::*;
#(
  parameter int unsigned PIXELS_PER_CHAR = DefPixelsPerChar,
  parameter int unsigned H_WIDTH         = DefHWidth,
  parameter int unsigned V_WIDTH         = DefVWidth,
  parameter int unsigned R_WIDTH         = DefRWidth,
  parameter int unsigned MA_WIDTH        = DefMaWidth
) (
  input  logic                pixel_clk,
  input  logic                reset,
  input  logic [H_WIDTH-1:0]  h_char_total,
  input  logic [H_WIDTH-1:0]  h_char_displayed,
  input  logic [H_WIDTH-1:0]  h_sync_pos,
  input  logic [3:0]          h_sync_width,
  input  logic [V_WIDTH-1:0]  v_char_total,
  input  logic [V_WIDTH-1:0]  v_char_displayed,
  input  logic [V_WIDTH-1:0]  v_sync_pos,
  input  logic [3:0]          v_sync_width,
  input  logic [R_WIDTH-1:0]  v_char_height,
  input  logic [R_WIDTH-1:0]  v_adjust,
  input  logic [MA_WIDTH-1:0] start_addr,
  output logic [MA_WIDTH-1:0] ma,
  output logic [R_WIDTH-1:0]  ra,
  output logic                h_sync,
  output logic                v_sync,
  output logic                h_active,
  output logic                v_active,
  output logic                de,
  output logic                char_en,
`ifdef VIDEO_TIMING_CURSOR_EN
  input  logic [MA_WIDTH-1:0] cursor_addr,
  input  logic [R_WIDTH-1:0]  cursor_start,
  input  logic [R_WIDTH-1:0]  cursor_end,
  input  logic [1:0]          cursor_mode,
  output logic                cursor,
`endif
  output logic                frame_start
);

  localparam int unsigned PxW = $clog2(PIXELS_PER_CHAR);
  localparam logic [PxW-1:0] PxLast = PxW'(PIXELS_PER_CHAR - 1);

  logic [PxW-1:0]           px_q, px_d;
  logic [H_WIDTH-1:0]       hc_q, hc_d;
  logic [R_WIDTH-1:0]       ra_q, ra_d;
  logic [V_WIDTH-1:0]       vc_q, vc_d;
  vstate_e                  vstate_q, vstate_d;
  logic [MA_WIDTH-1:0]      row_base_q, row_base_d;
  logic [VsyncCntWidth-1:0] vs_cnt_q, vs_cnt_d;

  logic               char_last, line_end, new_frame;
  logic [R_WIDTH:0]   ra_inc;
  logic [H_WIDTH:0]   hs_end;

  logic [MA_WIDTH-1:0] ma_d;
  logic                h_sync_d, v_sync_d, h_active_d, v_active_d, de_d;
  logic                char_en_d, frame_start_d;

  // Counter next state.
  always_comb begin
    char_last  = (px_q == PxLast);
    line_end   = char_last && (hc_q >= h_char_total);
    ra_inc     = {1'b0, ra_q} + (R_WIDTH + 1)'(1);
    px_d       = char_last ? '0 : px_q + PxW'(1);
    hc_d       = hc_q;
    ra_d       = ra_q;
    vc_d       = vc_q;
    vstate_d   = vstate_q;
    row_base_d = row_base_q;
    vs_cnt_d   = vs_cnt_q;
    new_frame  = 1'b0;

    // >= rather than == so a live shrink below the current count wraps next cell.
    if (char_last) hc_d = (hc_q >= h_char_total) ? '0 : hc_q + H_WIDTH'(1);

    if (line_end) begin
      unique case (vstate_q)
        VRows: begin
          if (ra_q >= v_char_height) begin
            ra_d       = '0;
            vc_d       = vc_q + V_WIDTH'(1);
            row_base_d = row_base_q + MA_WIDTH'(h_char_displayed);
            if (vc_q >= v_char_total) begin
              if (v_adjust != '0) vstate_d = VAdjust;
              else                new_frame = 1'b1;
            end
          end else begin
            ra_d = ra_inc[R_WIDTH-1:0];
          end
        end
        VAdjust: begin
          if (ra_inc >= {1'b0, v_adjust}) new_frame = 1'b1;
          else                            ra_d = ra_inc[R_WIDTH-1:0];
        end
      endcase

      if (new_frame) begin
        ra_d       = '0;
        vc_d       = '0;
        vstate_d   = VRows;
        row_base_d = start_addr;
      end

      // vsync length is counted in scanlines, independent of row boundaries.
      if ((vstate_d == VRows) && (vc_d == v_sync_pos) && (ra_d == '0)) begin
        vs_cnt_d = v_sync_width;
      end else if (vs_cnt_q != '0) begin
        vs_cnt_d = vs_cnt_q - VsyncCntWidth'(1);
      end
    end
  end

  // Output decode from the current counter state; registered below.
  always_comb begin
    hs_end        = {1'b0, h_sync_pos} + (H_WIDTH + 1)'(h_sync_width);
    ma_d          = row_base_q + MA_WIDTH'(hc_q);
    h_active_d    = (hc_q < h_char_displayed);
    v_active_d    = (vstate_q == VRows) && (vc_q < v_char_displayed);
    de_d          = h_active_d && v_active_d;
    h_sync_d      = (hc_q >= h_sync_pos) && ({1'b0, hc_q} < hs_end);
    v_sync_d      = (vs_cnt_q != '0);
    char_en_d     = char_last;
    frame_start_d = (px_q == '0) && (hc_q == '0) && (ra_q == '0) && (vc_q == '0) &&
                    (vstate_q == VRows);
  end

  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      px_q        <= '0;
      hc_q        <= '0;
      ra_q        <= '0;
      vc_q        <= '0;
      vstate_q    <= VRows;
      row_base_q  <= '0;
      vs_cnt_q    <= '0;
      ma          <= '0;
      ra          <= '0;
      h_sync      <= 1'b0;
      v_sync      <= 1'b0;
      h_active    <= 1'b0;
      v_active    <= 1'b0;
      de          <= 1'b0;
      char_en     <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      px_q        <= px_d;
      hc_q        <= hc_d;
      ra_q        <= ra_d;
      vc_q        <= vc_d;
      vstate_q    <= vstate_d;
      row_base_q  <= row_base_d;
      vs_cnt_q    <= vs_cnt_d;
      ma          <= ma_d;
      ra          <= ra_q;
      h_sync      <= h_sync_d;
      v_sync      <= v_sync_d;
      h_active    <= h_active_d;
      v_active    <= v_active_d;
      de          <= de_d;
      char_en     <= char_en_d;
      frame_start <= frame_start_d;
    end
  end

`ifdef VIDEO_TIMING_CURSOR_EN
  video_cursor #(
    .MA_WIDTH (MA_WIDTH),
    .R_WIDTH  (R_WIDTH)
  ) u_cursor (
    .pixel_clk    (pixel_clk),
    .reset        (reset),
    .frame_tick   (frame_start_d),
    .de_next      (de_d),
    .ma_next      (ma_d),
    .ra_next      (ra_q),
    .cursor_addr  (cursor_addr),
    .cursor_start (cursor_start),
    .cursor_end   (cursor_end),
    .cursor_mode  (cursor_mode),
    .cursor       (cursor)
  );
`endif

endmodule
